// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps all 2^NUM_IN input vectors through a combinational DUT,
// holding each for HOLD_CYCLES clocks and sampling f at the end of each hold window.
// The captured table is compared against a golden table latched at sweep start.
module truth_table_sequencer #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [(1<<NUM_IN)-1:0]   expected,
  output logic [NUM_IN-1:0]        abcd,
  input  logic                     f_in,
  output logic                     busy,
  output logic                     done,
  output logic [(1<<NUM_IN)-1:0]   truth_table,
  output logic                     pass,
  output logic [NUM_IN:0]          mismatch_count,
  output logic [NUM_IN-1:0]        first_fail_idx
);

  localparam int unsigned Depth = 1 << NUM_IN;
  // A one-cycle hold still needs a 1-bit counter that is permanently at its last value.
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [NUM_IN-1:0] IdxLast  = NUM_IN'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_IN-1:0]   idx_q, idx_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [Depth-1:0]    exp_q, exp_d;
  logic [Depth-1:0]    table_q, table_d;
  logic [NUM_IN:0]     mism_q, mism_d;
  logic [NUM_IN-1:0]   first_q, first_d;
  logic                pass_q, pass_d;

  // Next-state logic: sweep control, sampling and result accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    exp_d   = exp_q;
    table_d = table_q;
    mism_d  = mism_q;
    first_d = first_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          hold_d  = '0;
          exp_d   = expected;
          table_d = '0;
          mism_d  = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldLast) begin
          hold_d         = '0;
          table_d[idx_q] = f_in;
          if (f_in != exp_q[idx_q]) begin
            mism_d = mism_q + 1'b1;
            // Count still zero means this is the first miss of the sweep.
            if (mism_q == '0) begin
              first_d = idx_q;
            end
          end
          if (idx_q == IdxLast) begin
            state_d = StDone;
            // Resolve pass on the final sample so it is valid during the done pulse.
            pass_d  = (mism_d == '0);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mism_q  <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // Outputs decoded from registered state; vector is only driven while sweeping.
  always_comb begin
    busy           = (state_q == StRun);
    done           = (state_q == StDone);
    abcd           = (state_q == StRun) ? idx_q : '0;
    truth_table    = table_q;
    pass           = pass_q;
    mismatch_count = mism_q;
    first_fail_idx = first_q;
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Self-checking bench: scoreboard of expected sweep results and timing, checked by a
// negedge monitor; a second instance exercises the one-cycle hold build.
module tb_truth_table_sequencer;

  localparam int unsigned NumIn = 4;
  localparam int unsigned Hold  = 20;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] expected = '0;
  logic [3:0]  abcd;
  logic        f_in;
  logic        busy, done, pass;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  int          mode = 0;  // 0: XOR DUT, 1: f tied 1, 2: f tied 0

  logic        start1 = 1'b0;
  logic [15:0] expected1 = 16'h6996;
  logic [3:0]  abcd1;
  logic        f_in1, busy1, done1, pass1;
  logic [15:0] tt1;
  logic [4:0]  mm1;
  logic [3:0]  ff1;

  assign f_in  = (mode == 0) ? ^abcd : (mode == 1);
  assign f_in1 = ^abcd1;

  truth_table_sequencer #(.NUM_IN(NumIn), .HOLD_CYCLES(Hold)) u_dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .abcd(abcd), .f_in(f_in),
    .busy(busy), .done(done), .truth_table(truth_table), .pass(pass),
    .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx)
  );

  truth_table_sequencer #(.NUM_IN(NumIn), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .abcd(abcd1), .f_in(f_in1),
    .busy(busy1), .done(done1), .truth_table(tt1), .pass(pass1),
    .mismatch_count(mm1), .first_fail_idx(ff1)
  );

  typedef struct {
    int unsigned e0;    // cycle count right after the start-capturing edge
    logic [15:0] tt;
    int unsigned mm;
    int unsigned ff;
    logic        pass;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic ref_f(input int m, input int unsigned v);
    logic [3:0] b;
    b = v[3:0];
    if (m == 0) return ^b;
    return (m == 1);
  endfunction

  // Reference: captured table is f over all vectors, scored against the golden table.
  function automatic exp_t make_item(input int m, input logic [15:0] e, input int unsigned e0);
    exp_t it;
    it.e0 = e0;
    it.tt = '0;
    for (int i = 0; i < 16; i++) it.tt[i] = ref_f(m, i);
    it.mm = $countones(it.tt ^ e);
    it.ff = 0;
    for (int i = 15; i >= 0; i--) if (it.tt[i] != e[i]) it.ff = i;
    it.pass = (it.mm == 0);
    return it;
  endfunction

  task automatic issue(input int m, input logic [15:0] e, output int unsigned e0);
    mode     = m;
    expected = e;
    start    = 1'b1;
    e0       = cyc + 1;
    q.push_back(make_item(m, e, e0));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (q.size() > 0 && n < 2 * Depth * Hold + 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sweep_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: checks busy/done/abcd timing each cycle and results on every done pulse.
  exp_t        mon_it;
  int unsigned mon_end;
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        mon_it  = q[0];
        mon_end = mon_it.e0 + Depth * Hold;
        chk("busy", busy, (cyc >= mon_it.e0 && cyc < mon_end));
        chk("done", done, (cyc == mon_end));
        if (cyc >= mon_it.e0 && cyc < mon_end)
          chk("abcd", abcd, (cyc - mon_it.e0) / Hold);
        if (cyc == mon_it.e0) begin
          chk("tt_cleared", truth_table, 0);
          chk("mm_cleared", mismatch_count, 0);
          chk("pass_cleared", pass, 0);
        end
        if (cyc == mon_end) begin
          chk("truth_table", truth_table, mon_it.tt);
          chk("mismatch_count", mismatch_count, mon_it.mm);
          chk("first_fail_idx", first_fail_idx, mon_it.ff);
          chk("pass", pass, mon_it.pass);
          void'(q.pop_front());
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned e0, e0b;
    int          m;
    logic [15:0] e;
    exp_t        tmp;

    // Reset for two clocks
    repeat (2) @(posedge clk);
    #1;
    chk("rst_abcd", abcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mm", mismatch_count, 0);
    chk("rst_tt", truth_table, 0);
    chk("rst_ff", first_fail_idx, 0);
    chk("rst1_busy", busy1, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed sweeps
    issue(0, 16'h6996, e0); wait_idle();
    issue(0, 16'h6997, e0); wait_idle();
    issue(0, 16'h0000, e0); wait_idle();
    issue(1, 16'h0000, e0); wait_idle();

    // Start mid-sweep is ignored; golden table changing mid-sweep has no effect
    issue(0, 16'h6996, e0);
    wait_cyc(e0 + 5 * Hold + 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc(e0 + 8 * Hold + 2);
    expected = 16'h0000;
    wait_idle();

    // Reset at vector 7 aborts with no done pulse
    issue(0, 16'h6996, e0);
    wait_cyc(e0 + 7 * Hold + 4);
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_abcd", abcd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tt", truth_table, 0);
    chk("abort_mm", mismatch_count, 0);
    repeat (Depth * Hold + 10) @(posedge clk);
    #1;

    // Start held high: back-to-back sweeps separated by one idle cycle
    mode     = 0;
    expected = 16'h6996;
    start    = 1'b1;
    e0       = cyc + 1;
    e0b      = e0 + Depth * Hold + 2;
    q.push_back(make_item(0, 16'h6996, e0));
    q.push_back(make_item(0, 16'h6996, e0b));
    wait_cyc(e0b + 3);
    start = 1'b0;
    wait_idle();

    // Randomized sweeps, some with a matching golden table
    for (int k = 0; k < 6; k++) begin
      m = int'($urandom_range(0, 2));
      e = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        tmp = make_item(m, 16'h0000, 0);
        e   = tmp.tt;
      end
      issue(m, e, e0);
      wait_idle();
    end

    // One-cycle hold build: vector advances every clock, done 16 edges after start
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("h1_busy", busy1, 1);
      chk("h1_abcd", abcd1, i);
    end
    @(negedge clk);
    chk("h1_done", done1, 1);
    chk("h1_tt", tt1, 16'h6996);
    chk("h1_pass", pass1, 1);
    chk("h1_mm", mm1, 0);
    @(negedge clk);
    chk("h1_done_pulse", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
